mm_iddmm_arb: RTL

MM_IDDMM_ARB -- requirements
Module: mm_iddmm_arb

---
 rtl/mm_iddmm_arb.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mm_iddmm_arb.sv
// mm_iddmm_arb: two-requester round-robin arbiter in front of a shared IDDMM core.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   req[1:0]            per-requester request for the core
//   gnt[1:0]            one-hot grant, high from LOAD through DONE
//   go[1:0]             per-requester "operands loaded, start task"
//   s_wr_ena/addr/data  packed per-requester operand write ports
//                       (addr: AW bits per requester, data: {m1,m,y,x} 4N bits per requester)
//   m_wr_*              core operand write port, mirrors the owner's slice in LOAD
//   m_task_req          core task request level, high in RUN
//   m_task_end          core task completion pulse
//   m_res_val, m_res    core result strobe and data
//   res_q               last captured result
//   done[1:0], err[1:0] one-cycle completion / timeout pulses to the owner
//
// Build option: define MM_ARB_TIMEOUT_EN to build a RUN-state watchdog that
// gives up after TIMEOUT cycles and reports err together with done.
module mm_iddmm_arb #(
    parameter int K       = 128,
    parameter int N       = 32,
    parameter int AW      = 7,
    parameter int TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    output logic [1:0]        gnt,
    input  logic [1:0]        go,
    input  logic [1:0]        s_wr_ena,
    input  logic [2*AW-1:0]   s_wr_addr,
    input  logic [8*N-1:0]    s_wr_data,
    output logic              m_wr_ena,
    output logic [AW-1:0]     m_wr_addr,
    output logic [N-1:0]      m_wr_x,
    output logic [N-1:0]      m_wr_y,
    output logic [N-1:0]      m_wr_m,
    output logic [N-1:0]      m_wr_m1,
    output logic              m_task_req,
    input  logic              m_task_end,
    input  logic              m_res_val,
    input  logic [K-1:0]      m_res,
    output logic [K-1:0]      res_q,
    output logic [1:0]        done,
    output logic [1:0]        err
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t      state, state_d;
    logic        owner, owner_d;
    logic        last;              // last-served requester
    logic        timeout_hit;
    logic [4*N-1:0] own_data;

`ifdef MM_ARB_TIMEOUT_EN
    logic [31:0] wd_cnt;
    logic        tmo;               // DONE was entered through the watchdog

    // wd_cnt holds the number of completed RUN cycles, so the hit fires
    // during the TIMEOUT-th RUN cycle and DONE follows on the next edge.
    assign timeout_hit = (state == RUN) && (wd_cnt == 32'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            tmo    <= 1'b0;
        end else begin
            if (state == RUN) begin
                wd_cnt <= wd_cnt + 32'd1;
                tmo    <= timeout_hit && !m_task_end;
            end else begin
                wd_cnt <= '0;
            end
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = |32'(TIMEOUT);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
            res_q <= '0;
        end else begin
            state <= state_d;
            owner <= owner_d;
            if (state == DONE)
                last <= owner;
            if (state == RUN && m_res_val)
                res_q <= m_res;
        end
    end

    assign own_data = owner ? s_wr_data[4*N +: 4*N] : s_wr_data[0 +: 4*N];

    always_comb begin
        state_d    = state;
        owner_d    = owner;
        gnt        = '0;
        done       = '0;
        err        = '0;
        m_task_req = 1'b0;
        m_wr_ena   = 1'b0;
        m_wr_addr  = '0;
        m_wr_x     = '0;
        m_wr_y     = '0;
        m_wr_m     = '0;
        m_wr_m1    = '0;

        if (state != IDLE)
            gnt = owner ? 2'b10 : 2'b01;

        case (state)
            IDLE: begin
                if (|req) begin
                    state_d = LOAD;
                    // On a tie the requester not served last wins.
                    owner_d = (req == 2'b11) ? ~last : req[1];
                end
            end
            LOAD: begin
                m_wr_ena  = s_wr_ena[owner];
                m_wr_addr = owner ? s_wr_addr[AW +: AW] : s_wr_addr[0 +: AW];
                m_wr_x    = own_data[0   +: N];
                m_wr_y    = own_data[N   +: N];
                m_wr_m    = own_data[2*N +: N];
                m_wr_m1   = own_data[3*N +: N];
                if (go[owner])
                    state_d = RUN;
                else if (!req[owner])
                    state_d = IDLE;
            end
            RUN: begin
                m_task_req = 1'b1;
                if (m_task_end || timeout_hit)
                    state_d = DONE;
            end
            DONE: begin
                done    = owner ? 2'b10 : 2'b01;
`ifdef MM_ARB_TIMEOUT_EN
                if (tmo)
                    err = owner ? 2'b10 : 2'b01;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
